multi_speed_estimator: RTL and testbench
========================================

Name: multi_speed_estimator

Overview:
- Parametrised successor to the single-channel rotation-speed differencer.
- Samples N_CH encoder angle accumulators on a shared programmable tick and computes a per-channel signed angle delta.
- Smooths each delta with a power-of-two moving average and outputs omega with a valid strobe.
- Sits between the encoder counters and the motor speed controllers.

Parameters:
- N_CH, 2: number of independent angle channels.
- ANGLE_W, 32: angle input width (two's-complement, wrapping).
- OMEGA_W, 32: omega output width, signed.
- PERIOD, 1048576: clk cycles between samples; must be ≥4.
- AVG_DEPTH, 4: moving-average window in samples; power of two, ≥1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: run sampling; low freezes the block and forces re-prime.
- angle, input, N_CH*ANGLE_W: packed angles; channel i at [i*ANGLE_W +: ANGLE_W].
- omega, output, N_CH*OMEGA_W: packed averaged speed, in angle LSBs per PERIOD.
- omega_valid, output, 1: one-cycle pulse when omega updates with a full window.
- sample_tick, output, 1: one-cycle pulse on the sampling cycle.
- sat, output, N_CH: sticky per-channel saturation flag; cleared by reset.

Behaviour:
- Reset values: omega=0, omega_valid=0, sample_tick=0, sat=0. Reset also clears the counter, all history, sums and the previous-angle registers, and sets state=PRIME.
- Reset mid-operation: aborts any in-flight pipeline stage. No valid pulse is issued afterwards.
- Counter:
  - Counts 0..PERIOD-1 while enable=1, then wraps to 0.
  - sample_tick is combinational: high when count==PERIOD-1 and enable=1.
  - While enable=0 the counter holds at 0.
- Stage 1, on the edge ending a tick cycle T:
  - Latch angle into prev_angle.
  - Register delta = angle - prev_angle, modulo 2^ANGLE_W, interpreted as signed.
  - Wrap-around is therefore transparent: 0xFFFFFFF0 -> 0x00000010 gives +32.
- Stage 2, on the next edge:
  - Update the circular buffer: sum <= sum + delta - buf[wr_ptr]; buf[wr_ptr] <= delta; wr_ptr++ (mod AVG_DEPTH).
  - sum width is ANGLE_W + log2(AVG_DEPTH).
  - Compute omega = (sum + delta - buf[wr_ptr]) >>> log2(AVG_DEPTH). The shift is arithmetic and truncates toward minus infinity.
  - Resize to OMEGA_W: sign-extend, or truncate/saturate per the optional feature.
- Latency: omega and omega_valid change at the start of cycle T+2.
- State machine (shared by all channels):
  - PRIME: on a tick, capture prev_angle only; no delta is pushed. Go to FILL with fill_cnt=0.
  - FILL: each tick pushes a delta and increments fill_cnt. When fill_cnt reaches AVG_DEPTH, go to RUN. The stage-2 update of that final push asserts omega_valid.
  - RUN: every tick pushes a delta, updates omega and pulses omega_valid.
  - First valid output: occurs on the (AVG_DEPTH+1)-th tick after reset or enable.
  - In FILL, omega updates internally but omega_valid stays 0.
- enable falling (any state, including mid-pipeline):
  - Pending stage-2 updates complete, but no omega_valid is issued.
  - State goes to PRIME; buffers and sums are zeroed. omega holds its last value; sat holds.
- enable rising: the counter restarts from 0.
- Simultaneous reset and enable: reset wins.

Optional Feature:
- Macro: SPEED_SAT_EN.
- When defined:
  - If the shifted average exceeds the signed OMEGA_W range, clamp omega to 2^(OMEGA_W-1)-1 or -2^(OMEGA_W-1).
  - Set sat[i] (sticky).
- When undefined:
  - omega takes the low OMEGA_W bits (two's-complement wrap).
  - sat is tied to 0.
  - No clamp logic is synthesised.

Test Plan:
All directed tests use PERIOD=8, AVG_DEPTH=4, N_CH=2.
1. Reset hold 3 cycles, angles nonzero -> omega=0, omega_valid=0, sat=0, sample_tick=0. First sample_tick occurs 7 cycles after reset release.
2. ch0 angle +10 per tick from 0 -> no omega_valid on ticks 1-4; ticks 5 onward each give a valid pulse 2 cycles after sample_tick with omega[ch0]=10.
3. ch0 ramp crossing 0xFFFFFFF0 -> 0x00000010 in steps of 32 -> omega[ch0]=32 continuously, with no glitch at the wrap.
4. ch1 angle -6 per tick (0, 0xFFFFFFFA, ...) -> omega[ch1]=0xFFFFFFFA (-6). A step change from 10 to 20 per tick yields omega 12 (sum 50>>2), 15, 17, 20 on successive valid pulses.
5. enable low for 20 cycles in RUN, then high -> no omega_valid while low. The next valid pulse comes on the 5th tick after re-enable; omega holds its old value meanwhile.
6. OMEGA_W=16, delta +40000 per tick:
   - SPEED_SAT_EN defined -> omega=0x7FFF, sat[0]=1 and sat stays 1 after the input returns to 0.
   - Undefined -> omega=0x9C40, sat=0.

Source files
------------

// File: rtl/multi_speed_estimator.sv
// Multi-channel encoder speed estimator: ticked angle differencing followed by a power-of-two moving average.
// Optional macro SPEED_SAT_EN: clamp omega to the signed OMEGA_W range and raise sticky per-channel sat flags.
module multi_speed_estimator #(
   parameter int N_CH      = 2,
   parameter int ANGLE_W   = 32,
   parameter int OMEGA_W   = 32,
   parameter int PERIOD    = 1048576,
   parameter int AVG_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [N_CH*ANGLE_W-1:0] angle,
   output logic [N_CH*OMEGA_W-1:0] omega,
   output logic                    omega_valid,
   output logic                    sample_tick,
   output logic [N_CH-1:0]         sat
);
   localparam int LOG2_AVG = $clog2(AVG_DEPTH);
   localparam int SUM_W    = ANGLE_W + LOG2_AVG;
   localparam int CNT_W    = $clog2(PERIOD);
   localparam int PTR_W    = (AVG_DEPTH > 1) ? LOG2_AVG : 1;
   localparam int FILL_W   = $clog2(AVG_DEPTH + 1);

   typedef enum logic [1:0] {PRIME, FILL, RUN} state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [FILL_W-1:0]         fill_q;
   logic [PTR_W-1:0]          wr_ptr_q;
   logic [PTR_W-1:0]          wr_ptr_d;
   logic                      push_q;
   logic                      fire_q;
   logic                      valid_q;
   logic [ANGLE_W-1:0]        prev_q  [N_CH];
   logic signed [ANGLE_W-1:0] delta_q [N_CH];
   logic signed [ANGLE_W-1:0] hist_q  [N_CH][AVG_DEPTH];
   logic signed [SUM_W-1:0]   sum_q   [N_CH];
   logic signed [SUM_W-1:0]   sum_d   [N_CH];
   logic [OMEGA_W-1:0]        omega_q [N_CH];
   logic [OMEGA_W-1:0]        omega_d [N_CH];

   assign sample_tick = enable && (cnt_q == CNT_W'(PERIOD - 1));
   assign omega_valid = valid_q;

   // Counter, sequencing state and stage 1 (angle difference).
   // NOTE: every clocked block here uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         state_q <= PRIME;
         fill_q  <= '0;
         push_q  <= 1'b0;
         fire_q  <= 1'b0;
         for (int ch = 0; ch < N_CH; ch++) begin
            prev_q[ch]  <= '0;
            delta_q[ch] <= '0;
         end
      end else if (!enable) begin
         cnt_q   <= '0;
         state_q <= PRIME;
         fill_q  <= '0;
         push_q  <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         fire_q <= 1'b0;
         if (sample_tick) begin
            cnt_q <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
               prev_q[ch]  <= angle[ch*ANGLE_W +: ANGLE_W];
               // Modular subtraction makes encoder wrap-around transparent.
               delta_q[ch] <= angle[ch*ANGLE_W +: ANGLE_W] - prev_q[ch];
            end
            case (state_q)
               PRIME: begin
                  state_q <= FILL;
                  fill_q  <= '0;
               end
               FILL: begin
                  push_q <= 1'b1;
                  fill_q <= fill_q + FILL_W'(1);
                  if (fill_q == FILL_W'(AVG_DEPTH - 1)) begin
                     state_q <= RUN;
                     fire_q  <= 1'b1;
                  end
               end
               RUN: begin
                  push_q <= 1'b1;
                  fire_q <= 1'b1;
               end
               default: state_q <= PRIME;
            endcase
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef SPEED_SAT_EN
   localparam int EXT_W = (SUM_W > OMEGA_W) ? SUM_W : OMEGA_W;
   localparam logic signed [EXT_W-1:0] OMAX =
      signed'({{(EXT_W-OMEGA_W+1){1'b0}}, {(OMEGA_W-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] OMIN = ~OMAX;

   logic signed [EXT_W-1:0] avg_ext;
   logic [N_CH-1:0]         sat_d;
   logic [N_CH-1:0]         sat_q;
`endif

   // Stage 2 next values: running sum and the shifted, resized average.
   always_comb begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(AVG_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      sum_d    = '{default: '0};
      omega_d  = '{default: '0};
`ifdef SPEED_SAT_EN
      avg_ext  = '0;
      sat_d    = '0;
`endif
      for (int ch = 0; ch < N_CH; ch++) begin
         sum_d[ch] = sum_q[ch] + SUM_W'(delta_q[ch]) - SUM_W'(hist_q[ch][wr_ptr_q]);
`ifdef SPEED_SAT_EN
         avg_ext = EXT_W'(sum_d[ch] >>> LOG2_AVG);
         if (avg_ext > OMAX) begin
            omega_d[ch] = OMEGA_W'(OMAX);
            sat_d[ch]   = 1'b1;
         end else if (avg_ext < OMIN) begin
            omega_d[ch] = OMEGA_W'(OMIN);
            sat_d[ch]   = 1'b1;
         end else begin
            omega_d[ch] = OMEGA_W'(avg_ext);
         end
`else
         omega_d[ch] = OMEGA_W'(sum_d[ch] >>> LOG2_AVG);
`endif
      end
   end

   // NOTE: the history buffer is reset with the sum, since the sum must always equal its contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         valid_q  <= 1'b0;
         for (int ch = 0; ch < N_CH; ch++) begin
            sum_q[ch]   <= '0;
            omega_q[ch] <= '0;
            for (int d = 0; d < AVG_DEPTH; d++) hist_q[ch][d] <= '0;
         end
      end else if (!enable) begin
         wr_ptr_q <= '0;
         valid_q  <= 1'b0;
         for (int ch = 0; ch < N_CH; ch++) begin
            sum_q[ch] <= '0;
            for (int d = 0; d < AVG_DEPTH; d++) hist_q[ch][d] <= '0;
         end
      end else begin
         valid_q <= fire_q;
         if (push_q) begin
            wr_ptr_q <= wr_ptr_d;
            for (int ch = 0; ch < N_CH; ch++) begin
               sum_q[ch]            <= sum_d[ch];
               hist_q[ch][wr_ptr_q] <= delta_q[ch];
               if (fire_q) omega_q[ch] <= omega_d[ch];
            end
         end
      end
   end

`ifdef SPEED_SAT_EN
   always_ff @(posedge clk) begin
      if (reset)                              sat_q <= '0;
      else if (enable && push_q && fire_q)    sat_q <= sat_q | sat_d;
   end
   assign sat = sat_q;
`else
   assign sat = '0;
`endif

   always_comb begin
      omega = '0;
      for (int ch = 0; ch < N_CH; ch++) omega[ch*OMEGA_W +: OMEGA_W] = omega_q[ch];
   end
endmodule

// File: tb/tb_multi_speed_estimator.sv
// Directed bench for multi_speed_estimator (PERIOD=8, AVG_DEPTH=4, N_CH=2), plus a 16-bit omega instance.
module tb_multi_speed_estimator;
   localparam int PERIOD    = 8;
   localparam int AVG_DEPTH = 4;

`ifdef SPEED_SAT_EN
   localparam logic [15:0] BIG_O2  = 16'h7FFF;
   localparam logic        SAT_EXP = 1'b1;
`else
   localparam logic [15:0] BIG_O2  = 16'h9C40;
   localparam logic        SAT_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [63:0] angle;
   logic [63:0] angle2;
   logic [63:0] omega;
   logic [31:0] omega2;
   logic        omega_valid, omega_valid2;
   logic        sample_tick, sample_tick2;
   logic [1:0]  sat, sat2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   multi_speed_estimator #(
      .N_CH(2), .ANGLE_W(32), .OMEGA_W(32), .PERIOD(PERIOD), .AVG_DEPTH(AVG_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .angle(angle),
      .omega(omega), .omega_valid(omega_valid), .sample_tick(sample_tick), .sat(sat)
   );

   multi_speed_estimator #(
      .N_CH(2), .ANGLE_W(32), .OMEGA_W(16), .PERIOD(PERIOD), .AVG_DEPTH(AVG_DEPTH)
   ) dut16 (
      .clk(clk), .reset(reset), .enable(enable), .angle(angle2),
      .omega(omega2), .omega_valid(omega_valid2), .sample_tick(sample_tick2), .sat(sat2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b1;
      repeat (3) step();
      reset = 1'b0;
   endtask

   // Advance to the next sample_tick cycle; an expired bound counts as a failed comparison.
   task automatic wait_tick();
      int n = 0;
      while (!sample_tick && n < 4 * PERIOD) begin
         step();
         n++;
      end
      if (!sample_tick) begin
         n_checks++;
         $display("FAIL tick_timeout: no sample_tick within %0d cycles", 4 * PERIOD);
      end
   endtask

   // Present angles on a tick cycle, then sample the outputs two cycles later.
   task automatic do_tick(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                          output logic v, output logic [31:0] o0, output logic [31:0] o1,
                          output logic v2, output logic [15:0] o2, output logic s2);
      wait_tick();
      angle  = {a1, a0};
      angle2 = {32'd0, a2};
      step();
      step();
      v  = omega_valid;
      o0 = omega[31:0];
      o1 = omega[63:32];
      v2 = omega_valid2;
      o2 = omega2[15:0];
      s2 = sat2[0];
   endtask

   task automatic test_reset();
      int n;
      reset  = 1'b1;
      enable = 1'b1;
      angle  = {32'h5678_0000, 32'h0000_1234};
      angle2 = {32'd0, 32'h99};
      repeat (3) step();
      n_checks++; if (omega !== 64'd0)    $display("FAIL reset_omega: got %h want 0", omega); else n_pass++;
      n_checks++; if (omega_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", omega_valid); else n_pass++;
      n_checks++; if (sat !== 2'b00)      $display("FAIL reset_sat: got %b want 00", sat); else n_pass++;
      n_checks++; if (sample_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", sample_tick); else n_pass++;
      n_checks++; if (omega2 !== 32'd0 || sat2 !== 2'b00)
         $display("FAIL reset_dut16: got omega %h sat %b want 0/00", omega2, sat2); else n_pass++;
      reset = 1'b0;
      n = 0;
      while (!sample_tick && n < 4 * PERIOD) begin
         step();
         n++;
      end
      n_checks++; if (n !== 7) $display("FAIL first_tick_delay: got %0d want 7", n); else n_pass++;
      n_checks++; if (sample_tick2 !== 1'b1) $display("FAIL first_tick_dut16: got %b want 1", sample_tick2); else n_pass++;
   endtask

   task automatic test_ramp();
      logic v, v2, s2;
      logic [31:0] o0, o1;
      logic [15:0] o2;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         do_tick(32'(10 * (k - 1)), 32'd0, 32'd0, v, o0, o1, v2, o2, s2);
         n_checks++;
         if (v !== (k >= 5)) $display("FAIL ramp_valid tick %0d: got %b want %b", k, v, k >= 5); else n_pass++;
         if (k >= 5) begin
            n_checks++;
            if (o0 !== 32'd10 || o1 !== 32'd0)
               $display("FAIL ramp_omega tick %0d: got %0d/%0d want 10/0", k, o0, o1);
            else n_pass++;
         end
      end
   endtask

   task automatic test_wrap();
      logic v, v2, s2;
      logic [31:0] o0, o1, a0;
      logic [15:0] o2;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         a0 = 32'hFFFF_FF50 + 32'(32 * (k - 1));
         do_tick(a0, 32'd0, 32'd0, v, o0, o1, v2, o2, s2);
         n_checks++;
         if (v !== (k >= 5)) $display("FAIL wrap_valid tick %0d: got %b want %b", k, v, k >= 5); else n_pass++;
         if (k >= 5) begin
            n_checks++;
            if (o0 !== 32'd32) $display("FAIL wrap_omega tick %0d: got %h want 00000020", k, o0); else n_pass++;
         end
      end
   endtask

   task automatic test_negative_step();
      logic v, v2, s2;
      logic [31:0] o0, o1, a0, a1;
      logic [15:0] o2;
      logic [31:0] exp0 [10];
      exp0 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd10, 32'd10, 32'd12, 32'd15, 32'd17, 32'd20};
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         a0 = (k <= 6) ? 32'(10 * (k - 1)) : 32'(50 + 20 * (k - 6));
         a1 = 32'(-6 * (k - 1));
         do_tick(a0, a1, 32'd0, v, o0, o1, v2, o2, s2);
         if (k >= 5) begin
            n_checks++;
            if (v !== 1'b1 || o0 !== exp0[k-1] || o1 !== 32'hFFFF_FFFA)
               $display("FAIL step_omega tick %0d: got v=%b %0d/%h want 1 %0d/fffffffa", k, v, o0, o1, exp0[k-1]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_enable();
      logic v, v2, s2;
      logic [31:0] o0, o1;
      logic [15:0] o2;
      int bad, n;
      do_reset();
      for (int k = 1; k <= 6; k++) do_tick(32'(10 * (k - 1)), 32'd0, 32'd0, v, o0, o1, v2, o2, s2);
      n_checks++; if (v !== 1'b1 || o0 !== 32'd10) $display("FAIL en_run: got v=%b %0d want 1 10", v, o0); else n_pass++;
      wait_tick();
      angle = {32'd0, 32'd60};
      step();
      enable = 1'b0;
      step();
      n_checks++;
      if (omega_valid !== 1'b0 || omega[31:0] !== 32'd10)
         $display("FAIL en_drop_pending: got v=%b %0d want 0 10", omega_valid, omega[31:0]);
      else n_pass++;
      bad = 0;
      repeat (19) begin
         step();
         if (omega_valid !== 1'b0 || sample_tick !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL en_low_pulses: got %0d want 0", bad); else n_pass++;
      enable = 1'b1;
      n = 0;
      while (!sample_tick && n < 4 * PERIOD) begin
         step();
         n++;
      end
      n_checks++; if (n !== 7) $display("FAIL en_restart_delay: got %0d want 7", n); else n_pass++;
      for (int j = 1; j <= 5; j++) begin
         do_tick(32'(1000 + 30 * (j - 1)), 32'd0, 32'd0, v, o0, o1, v2, o2, s2);
         n_checks++;
         if (v !== (j == 5) || o0 !== ((j == 5) ? 32'd30 : 32'd10))
            $display("FAIL en_refill tick %0d: got v=%b %0d want %b %0d", j, v, o0, j == 5, (j == 5) ? 30 : 10);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midop();
      logic v, v2, s2;
      logic [31:0] o0, o1;
      logic [15:0] o2;
      int bad;
      do_reset();
      for (int k = 1; k <= 6; k++) do_tick(32'(10 * (k - 1)), 32'd0, 32'd0, v, o0, o1, v2, o2, s2);
      wait_tick();
      angle = {32'd0, 32'd60};
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if (omega_valid !== 1'b0 || omega[31:0] !== 32'd0)
         $display("FAIL midreset: got v=%b %0d want 0 0", omega_valid, omega[31:0]);
      else n_pass++;
      bad = 0;
      repeat (3 * PERIOD) begin
         step();
         if (omega_valid !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL midreset_pulses: got %0d want 0", bad); else n_pass++;
   endtask

   task automatic test_sat();
      logic v, v2, s2;
      logic [31:0] o0, o1;
      logic [15:0] o2;
      logic [15:0] exp2 [12];
      exp2 = '{16'd0, 16'd0, 16'd0, 16'd0, BIG_O2, BIG_O2, 16'h7530, 16'h4E20, 16'h2710, 16'd0, 16'd0, 16'd0};
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         do_tick(32'd0, 32'd0, 32'(40000 * ((k <= 6) ? k - 1 : 5)), v, o0, o1, v2, o2, s2);
         if (k >= 5) begin
            n_checks++;
            if (v2 !== 1'b1 || o2 !== exp2[k-1] || s2 !== SAT_EXP)
               $display("FAIL sat16 tick %0d: got v=%b %h sat=%b want 1 %h %b", k, v2, o2, s2, exp2[k-1], SAT_EXP);
            else n_pass++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      angle  = '0;
      angle2 = '0;
      test_reset();
      test_ramp();
      test_wrap();
      test_negative_step();
      test_enable();
      test_reset_midop();
      test_sat();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
